// File: rtl/deinterlace_pkg.sv
// Shared types and constants for the deinterlacer line-buffer read path.
// Imported by the line-buffer reader and its output skid FIFO.
package deinterlace_pkg;

  localparam int LINE_W      = 640;
  localparam int FRAME_LINES = 480;

  typedef logic [7:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    WRAP
  } rd_state_t;

  typedef struct packed {
    pixel_t data;
    logic   sol;
    logic   eol;
    logic   eof;
  } obuf_entry_t;

endpackage

// File: rtl/pix_skid_fifo.sv
// Small power-of-two FIFO of tagged pixels feeding the output stream.
// Head entry is presented combinationally; push and pop may coincide.
module pix_skid_fifo
  import deinterlace_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  obuf_entry_t   din,
  output obuf_entry_t   dout,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  obuf_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign dout = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/line_buf_reader.sv
// Drains complete lines from the line buffer into a ready/valid pixel
// stream, absorbing the RAM read latency and tracking frame position.
module line_buf_reader #(
  parameter int LINE_W      = deinterlace_pkg::LINE_W,
  parameter int FRAME_LINES = deinterlace_pkg::FRAME_LINES,
  parameter int OBUF_DEPTH  = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       buf_full,
  output logic       buf_rd_req,
  input  logic [7:0] buf_q,
  output logic [7:0] pix_data,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic       pix_sol,
  output logic       pix_eol,
  output logic       pix_eof,
  output logic [9:0] line_idx,
  output logic       sync_err
);

  import deinterlace_pkg::*;

  localparam int         CW    = $clog2(OBUF_DEPTH) + 1;
  localparam logic [9:0] LAST  = 10'(LINE_W - 1);
  localparam logic [9:0] PEN   = 10'(LINE_W - 2);
  localparam logic [9:0] FLAST = 10'(FRAME_LINES - 1);
  localparam logic [CW:0] DEPTH_V  = (CW+1)'(OBUF_DEPTH);
  localparam logic [CW:0] DEPTH_M2 = (CW+1)'(OBUF_DEPTH - 2);

  rd_state_t   state;
  logic [9:0]  rd_idx;
  logic        cap_v;
  logic        cap_sol;
  logic        cap_eol;
  logic [CW-1:0] occ;
  logic [CW:0] used;
  logic        credit1;
  logic        credit2;
  logic        at_last;
  logic        commit;
  logic        pop;
  obuf_entry_t wr_e;
  obuf_entry_t rd_e;

  assign at_last = (rd_idx == LAST);
  assign used    = {1'b0, occ} + {{CW{1'b0}}, cap_v};
  assign credit1 = (used < DEPTH_V);
  assign credit2 = (used <= DEPTH_M2);

  // Stepping onto the last index needs room for it and the forced wrap pixel.
  always_comb begin
    buf_rd_req = 1'b0;
    if (state == DRAIN) begin
      unique case (1'b1)
        at_last:         buf_rd_req = credit1;
        (rd_idx == PEN): buf_rd_req = buf_full & credit2;
        default:         buf_rd_req = buf_full & credit1;
      endcase
    end
  end

  assign commit = (state == DRAIN) && (at_last || buf_rd_req);

  always_comb begin
    wr_e      = '0;
    wr_e.data = buf_q;
    wr_e.sol  = cap_sol;
    wr_e.eol  = cap_eol;
    wr_e.eof  = cap_eol && (line_idx == FLAST);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rd_idx   <= '0;
      cap_v    <= 1'b0;
      cap_sol  <= 1'b0;
      cap_eol  <= 1'b0;
      line_idx <= '0;
      sync_err <= 1'b0;
    end else begin
      cap_v   <= commit;
      cap_sol <= commit && (rd_idx == '0);
      cap_eol <= commit && at_last;
      if (cap_v && cap_eol)
        line_idx <= (line_idx == FLAST) ? '0 : line_idx + 10'd1;
      unique case (state)
        IDLE: begin
          rd_idx <= '0;
          if (buf_full) state <= DRAIN;
        end
        DRAIN: begin
          if (!buf_full && !at_last) begin
            sync_err <= 1'b1;
            rd_idx   <= '0;
            state    <= IDLE;
          end else if (commit) begin
            if (at_last) begin
              rd_idx <= '0;
              state  <= WRAP;
            end else begin
              rd_idx <= rd_idx + 10'd1;
            end
          end
        end
        WRAP: begin
          if (buf_full) sync_err <= 1'b1;
          rd_idx <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  pix_skid_fifo #(
    .DEPTH (OBUF_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (cap_v),
    .pop   (pop),
    .din   (wr_e),
    .dout  (rd_e),
    .count (occ)
  );

  assign pix_valid = (occ != '0);
  assign pop       = pix_valid & pix_ready;
  assign pix_data  = rd_e.data;
  assign pix_sol   = pix_valid & rd_e.sol;
  assign pix_eol   = pix_valid & rd_e.eol;
  assign pix_eof   = pix_valid & rd_e.eof;

endmodule

// File: tb/tb_line_buf_reader.sv
// Bench for line_buf_reader: behavioural line buffer, pixel scoreboard,
// table of whole-line runs plus backpressure, error and reset sequences.
module tb_line_buf_reader;
  import deinterlace_pkg::*;

  localparam int LW = 640;
  localparam int FL = 2;
  localparam int OD = 4;

  typedef struct packed {
    logic [7:0] data;
    logic       sol;
    logic       eol;
    logic       eof;
  } exp_t;

  typedef struct {
    int mode;
    int lofs;
    int line_after;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       buf_full;
  logic       buf_rd_req;
  logic [7:0] buf_q;
  logic [7:0] pix_data;
  logic       pix_valid;
  logic       pix_ready = 1'b0;
  logic       pix_sol;
  logic       pix_eol;
  logic       pix_eof;
  logic [9:0] line_idx;
  logic       sync_err;

  logic       fill_go = 1'b0;
  logic       kill = 1'b0;
  logic [9:0] bptr;
  logic [7:0] mem [LW];

  int tests = 0;
  int fails = 0;
  int mode = 3;
  int cyc = 0;
  int cur_line = 0;
  int maxc = 0;
  exp_t exp_q[$];

  always #5 clock = ~clock;

  line_buf_reader #(
    .LINE_W      (LW),
    .FRAME_LINES (FL),
    .OBUF_DEPTH  (OD)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .buf_full   (buf_full),
    .buf_rd_req (buf_rd_req),
    .buf_q      (buf_q),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_sol    (pix_sol),
    .pix_eol    (pix_eol),
    .pix_eof    (pix_eof),
    .line_idx   (line_idx),
    .sync_err   (sync_err)
  );

  // Line buffer: registered read of the presented address, wraps at LW-1.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      bptr     <= '0;
      buf_full <= 1'b0;
      buf_q    <= '0;
    end else begin
      buf_q <= mem[bptr];
      if (kill) begin
        buf_full <= 1'b0;
        bptr     <= '0;
      end else if (fill_go) begin
        buf_full <= 1'b1;
        bptr     <= '0;
      end else if (buf_rd_req) begin
        if (int'(bptr) == LW - 1) begin
          bptr     <= '0;
          buf_full <= 1'b0;
        end else begin
          bptr <= bptr + 10'd1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clock);
    #1;
    cyc++;
    case (mode)
      0: pix_ready = 1'b1;
      1: pix_ready = (cyc % 3 == 0);
      2: pix_ready = 1'b0;
      default: ;
    endcase
  end

  initial forever begin
    exp_t e;
    @(negedge clock);
    if (int'(dut.occ) > maxc) maxc = int'(dut.occ);
    if (reset && pix_valid && pix_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL extra_pix: got %0h with none expected", pix_data);
      end else begin
        e = exp_q.pop_front();
        check("pix", 32'({pix_data, pix_sol, pix_eol, pix_eof}), 32'(e));
      end
    end
  end

  task automatic load_line(input int lofs, input int n);
    for (int i = 0; i < LW; i++) mem[i] = 8'((i + lofs) & 255);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.data = 8'((i + lofs) & 255);
      e.sol  = (i == 0);
      e.eol  = (i == LW - 1);
      e.eof  = (i == LW - 1) && (cur_line == FL - 1);
      exp_q.push_back(e);
    end
    @(negedge clock);
    fill_go = 1'b1;
    @(negedge clock);
    fill_go = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int i = 0;
    while (exp_q.size() != 0 && i < 6000) begin
      @(negedge clock);
      i++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clock);
  endtask

  task automatic wait_ptr(input int v);
    int i = 0;
    while (int'(bptr) != v && i < 6000) begin
      @(negedge clock);
      i++;
    end
    check("ptr_reach", 32'(bptr), 32'(v));
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_rd_req"},   32'(buf_rd_req), 32'd0);
    check({tag, "_valid"},    32'(pix_valid),  32'd0);
    check({tag, "_sol"},      32'(pix_sol),    32'd0);
    check({tag, "_eol"},      32'(pix_eol),    32'd0);
    check({tag, "_eof"},      32'(pix_eof),    32'd0);
    check({tag, "_line_idx"}, 32'(line_idx),   32'd0);
    check({tag, "_sync_err"}, 32'(sync_err),   32'd0);
  endtask

  initial begin
    vec_t vt[3];
    vt[0] = '{0, 0, 1};
    vt[1] = '{1, 0, 0};
    vt[2] = '{0, 77, 1};

    repeat (3) @(negedge clock);
    check_reset_outs("rst");
    reset = 1'b1;
    repeat (2) @(negedge clock);

    for (int k = 0; k < 3; k++) begin
      mode = vt[k].mode;
      load_line(vt[k].lofs, LW);
      wait_drain("drain_vec");
      cur_line = (cur_line + 1) % FL;
      check("line_idx_vec", 32'(line_idx), 32'(vt[k].line_after));
      check("sync_err_vec", 32'(sync_err), 32'd0);
    end
    check("fifo_over_depth", 32'(maxc > OD), 32'd0);

    // Line arrives with the sink stalled: only the FIFO depth is read.
    mode = 2;
    repeat (2) @(negedge clock);
    load_line(9, LW);
    repeat (20) @(negedge clock);
    check("stall_ptr", 32'(bptr), 32'd4);
    check("stall_rd_req", 32'(buf_rd_req), 32'd0);
    check("stall_valid", 32'(pix_valid), 32'd1);
    check("stall_head", 32'(pix_data), 32'd9);
    mode = 0;
    wait_drain("drain_stall");
    cur_line = (cur_line + 1) % FL;
    check("line_idx_stall", 32'(line_idx), 32'(cur_line));

    // Stall at the line end with a single credit left.
    load_line(21, LW);
    wait_ptr(LW - 3);
    mode = 3;
    #1 pix_ready = 1'b0;
    repeat (5) @(negedge clock);
    check("end_ptr", 32'(bptr), 32'(LW - 2));
    check("end_rd_req", 32'(buf_rd_req), 32'd0);
    #1 pix_ready = 1'b1;
    wait_drain("drain_end");
    cur_line = (cur_line + 1) % FL;
    check("line_idx_end", 32'(line_idx), 32'(cur_line));
    check("sync_err_end", 32'(sync_err), 32'd0);

    // Buffer loses its line mid-drain.
    mode = 0;
    load_line(40, 101);
    wait_ptr(100);
    kill = 1'b1;
    @(negedge clock);
    kill = 1'b0;
    repeat (3) @(negedge clock);
    check("err_flag", 32'(sync_err), 32'd1);
    check("err_state", 32'(dut.state), 32'(IDLE));
    wait_drain("drain_err");
    check("line_idx_err", 32'(line_idx), 32'(cur_line));

    load_line(5, LW);
    wait_drain("drain_after_err");
    cur_line = (cur_line + 1) % FL;
    check("line_idx_after_err", 32'(line_idx), 32'(cur_line));
    check("sync_err_sticky", 32'(sync_err), 32'd1);

    // Asynchronous reset in the middle of a line.
    load_line(3, LW);
    wait_ptr(300);
    @(negedge clock);
    #2 reset = 1'b0;
    #1 check_reset_outs("async");
    exp_q.delete();
    cur_line = 0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    load_line(0, LW);
    wait_drain("drain_post_rst");
    cur_line = (cur_line + 1) % FL;
    check("line_idx_post_rst", 32'(line_idx), 32'(cur_line));
    check("sync_err_post_rst", 32'(sync_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/line_buf_reader.md
Name: line_buf_reader

Overview:
- Read-side controller for the 640-pixel line buffer.
- Waits for the buffer to report a complete line, then drains it by driving the buffer's read request.
- Absorbs the buffer RAM's one-cycle read latency and re-emits the line as a ready/valid pixel stream, with start/end-of-line and end-of-frame markers, to the deinterlacer output stage.
- Tracks line count per frame and flags loss of lockstep with the buffer.

Parameters:
- LINE_W, 640, pixels per line; must equal the buffer's fill size.
- FRAME_LINES, 480, lines per frame, used for pix_eof and line_idx wrap.
- OBUF_DEPTH, 4, output skid FIFO entries; power of two, minimum 2.

Ports:
- clock  in  1  single system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset; reset is asserted while low.
- buf_full  in  1  line buffer holds a complete line; drops the cycle after the buffer's read pointer wraps.
- buf_rd_req  out  1  advance the buffer read pointer.
- buf_q  in  8  buffer read data; valid for the address presented one cycle earlier.
- pix_data  out  8  output pixel.
- pix_valid  out  1  pix_data is valid.
- pix_ready  in  1  downstream accepts; a transfer occurs when valid and ready are both high.
- pix_sol  out  1  qualifies pixel 0 of a line.
- pix_eol  out  1  qualifies pixel LINE_W-1.
- pix_eof  out  1  qualifies the last pixel of line FRAME_LINES-1.
- line_idx  out  10  index of the line currently being drained.
- sync_err  out  1  sticky; set when lockstep with the buffer is lost.

Behaviour:
- Reset (reset low, asynchronous): buf_rd_req=0, pix_valid=0, pix_sol=0, pix_eol=0, pix_eof=0, line_idx=0, sync_err=0, output FIFO empty, state IDLE, rd_idx=0.
- rd_idx mirrors the buffer read pointer.
- States:
  - IDLE: go to DRAIN when buf_full=1.
  - DRAIN: active while buf_full=1; on the commit of index LINE_W-1, go to WRAP.
  - WRAP: one cycle; expect buf_full=0; return to IDLE. A fresh buf_full is honoured only from IDLE.
- Commit rule (a commit is a pixel index whose data will be captured):
  - In DRAIN, index rd_idx commits in the cycle it is presented, if either:
    - rd_idx < LINE_W-1 and buf_rd_req=1, or
    - rd_idx = LINE_W-1 (the buffer wraps unconditionally at this index).
- Capture: a commit in cycle t writes buf_q into the output FIFO in cycle t+1, tagged sol/eol/eof. Fixed one-cycle latency.
- Credit rule: credits = OBUF_DEPTH − occupancy − in-flight captures (0 or 1).
  - buf_rd_req = (state==DRAIN) and credits ≥ 1 for rd_idx < LINE_W-2.
  - At rd_idx = LINE_W-2, advancing requires credits ≥ 2, reserving the slot for the forced LINE_W-1 commit.
  - With buf_rd_req low, rd_idx holds and the buffer pointer holds.
- Throughput: one pixel per clock while pix_ready=1 and the buffer is full.
- Output FIFO behaviour:
  - Head drives pix_data, pix_valid and the markers combinationally.
  - Pop on valid & ready.
  - Simultaneous push and pop at full occupancy is legal.
  - Overflow is impossible by the credit rule.
- line_idx:
  - Increments on the capture of the LINE_W-1 pixel.
  - Wraps FRAME_LINES-1 → 0 on the same capture that carries pix_eof.
- sync_err is set (sticky until reset) if either:
  - buf_full falls while in DRAIN with rd_idx ≠ LINE_W-1, or
  - buf_full is still 1 in WRAP.
  - On error, return to IDLE and reset rd_idx=0.
- Reset mid-line: the output FIFO is flushed and partial-line pixels are lost. The buffer shares the reset, so both restart at index 0.
- Width rules:
  - rd_idx is 10 bits; max value LINE_W-1.
  - Occupancy counter is clog2(OBUF_DEPTH)+1 bits.
  - No arithmetic on pixel data.

Decomposition:
- Shared package deinterlace_pkg:
  - LINE_W and FRAME_LINES constants.
  - pixel_t (8-bit) typedef.
  - Enum rd_state_t {IDLE, DRAIN, WRAP}.
  - Struct obuf_entry_t {pixel_t data; logic sol, eol, eof}.
- Sub-module pix_skid_fifo: parameterised OBUF_DEPTH FIFO of obuf_entry_t.
  - Ports: push, pop, entry in/out, count.
  - Reset is asynchronous, active-low.

Test Plan:
- Fill the buffer with pixel value = index mod 256; hold pix_ready=1 → 640 transfers of 0,1,…,255,0,…,127 on consecutive cycles. pix_sol on the first transfer, pix_eol on the 640th, line_idx 0→1.
- Toggle pix_ready 1-of-3 cycles → data sequence identical to the previous case, no loss or duplication, output FIFO count never exceeds 4.
- Hold pix_ready=0 when the line arrives → exactly 4 pixels captured (0..3), buf_rd_req=0. Then release → pixels 4..639 follow in order.
- Backpressure at the line end (pix_ready=0 with rd_idx=638, credits=1) → buf_rd_req stays 0 until credits ≥ 2. Pixels 638 and 639 are both delivered, sync_err=0.
- Run 3 lines with FRAME_LINES=2 → pix_eof on line 1 pixel 639, line_idx sequence 0,1,0,1.
- Force buf_full low at rd_idx=100 → sync_err=1 and state IDLE. Next buf_full yields pixel 0 with pix_sol. Pull reset low mid-line → all outputs at reset values immediately, asynchronously.
